// File: rtl/lorenz_pkg.sv
// Shared definitions for the sequential Lorenz Euler solver: default fixed-point
// format, saturation bounds and the solver FSM state encoding.
package lorenz_pkg;

  localparam int DEF_WIDTH = 27;
  localparam int DEF_FRAC  = 20;

  localparam logic signed [DEF_WIDTH-1:0] ONE     = 27'sh0100000;
  localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = 27'sh3FFFFFF;
  localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = 27'sh4000000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_UPD  = 3'd3,
    S_HOLD = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/lorenz_solver_seq_fixed_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, rescale by FRAC,
// then either clamp to the signed range or keep the sign bit plus low result bits.
module fixed_mul_sat
  import lorenz_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  localparam logic signed [2*WIDTH-1:0] MAX_X = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MIN_X = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_ext_s;
  logic signed [2*WIDTH-1:0] b_ext_s;
  logic signed [2*WIDTH-1:0] full_s;
  logic signed [2*WIDTH-1:0] shr_s;

  // product, rescale and range handling
  always_comb begin
    a_ext_s = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    b_ext_s = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    full_s  = a_ext_s * b_ext_s;
    shr_s   = full_s >>> FRAC;
    p_o     = shr_s[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (shr_s > MAX_X) begin
        p_o = MAX_W;
      end else if (shr_s < MIN_X) begin
        p_o = MIN_W;
      end else begin
        p_o = shr_s[WIDTH-1:0];
      end
    end else begin
      p_o = {full_s[2*WIDTH-1], full_s[WIDTH-2+FRAC:FRAC]};
    end
  end

endmodule

// File: rtl/lorenz_solver_seq.sv
// Sequential Lorenz Euler integrator: one shared multiplier produces seven
// products per step, followed by a single simultaneous x/y/z update.
module lorenz_solver_seq
  import lorenz_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int CNT_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [WIDTH-1:0] dt,
  input  logic [WIDTH-1:0] sigma,
  input  logic [WIDTH-1:0] beta,
  input  logic [WIDTH-1:0] rho,
  input  logic [WIDTH-1:0] init_x,
  input  logic [WIDTH-1:0] init_y,
  input  logic [WIDTH-1:0] init_z,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] SMAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

  // Sign-extended add/subtract; overflow is clamped only when SATURATE is set.
  function automatic logic [WIDTH-1:0] fx_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             neg);
    logic [WIDTH:0] ae;
    logic [WIDTH:0] be;
    logic [WIDTH:0] s;
    ae = {a[WIDTH-1], a};
    be = {b[WIDTH-1], b};
    s  = neg ? (ae - be) : (ae + be);
    if ((SATURATE != 0) && (s[WIDTH] != s[WIDTH-1])) begin
      fx_add = s[WIDTH] ? SMIN : SMAX;
    end else begin
      fx_add = s[WIDTH-1:0];
    end
  endfunction

  state_e           state_q;
  logic [2:0]       phase_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [WIDTH-1:0] dt_q, sigma_q, beta_q, rho_q;
  logic [CNT_W-1:0] nsteps_q, cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q [7];
  logic             out_valid_q, busy_q, done_q;
  logic [WIDTH-1:0] mul_a_s, mul_b_s, mul_p_s;

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // operand selection for the shared multiplier, one product per phase
  always_comb begin
    mul_a_s = ZERO_W;
    mul_b_s = ZERO_W;
    case (phase_q)
      3'd0: begin mul_a_s = sigma_q;                       mul_b_s = fx_add(y_q, x_q, 1'b1); end
      3'd1: begin mul_a_s = p_q[0];                        mul_b_s = dt_q;                   end
      3'd2: begin mul_a_s = x_q;                           mul_b_s = fx_add(rho_q, z_q, 1'b1); end
      3'd3: begin mul_a_s = fx_add(p_q[2], y_q, 1'b1);     mul_b_s = dt_q;                   end
      3'd4: begin mul_a_s = x_q;                           mul_b_s = y_q;                    end
      3'd5: begin mul_a_s = beta_q;                        mul_b_s = z_q;                    end
      3'd6: begin mul_a_s = fx_add(p_q[4], p_q[5], 1'b1);  mul_b_s = dt_q;                   end
      default: begin mul_a_s = ZERO_W;                     mul_b_s = ZERO_W;                 end
    endcase
  end

  fixed_mul_sat #(
    .WIDTH   (WIDTH),
    .FRAC    (FRAC),
    .SATURATE(SATURATE)
  ) u_mul (
    .a_i(mul_a_s),
    .b_i(mul_b_s),
    .p_o(mul_p_s)
  );

  // solver FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 3'd0;
      x_q         <= ZERO_W;
      y_q         <= ZERO_W;
      z_q         <= ZERO_W;
      dt_q        <= ZERO_W;
      sigma_q     <= ZERO_W;
      beta_q      <= ZERO_W;
      rho_q       <= ZERO_W;
      nsteps_q    <= ZERO_C;
      cnt_q       <= ZERO_C;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        p_q[i] <= ZERO_W;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          x_q      <= init_x;
          y_q      <= init_y;
          z_q      <= init_z;
          dt_q     <= dt;
          sigma_q  <= sigma;
          beta_q   <= beta;
          rho_q    <= rho;
          nsteps_q <= num_steps;
          cnt_q    <= ZERO_C;
          phase_q  <= 3'd0;
          state_q  <= S_MUL;
        end
        S_MUL: begin
          case (phase_q)
            3'd0:    p_q[0] <= mul_p_s;
            3'd1:    p_q[1] <= mul_p_s;
            3'd2:    p_q[2] <= mul_p_s;
            3'd3:    p_q[3] <= mul_p_s;
            3'd4:    p_q[4] <= mul_p_s;
            3'd5:    p_q[5] <= mul_p_s;
            3'd6:    p_q[6] <= mul_p_s;
            default: p_q[0] <= p_q[0];
          endcase
          if (phase_q == 3'd6) begin
            phase_q <= 3'd0;
            state_q <= S_UPD;
          end else begin
            phase_q <= phase_q + 3'd1;
          end
        end
        S_UPD: begin
          x_q         <= fx_add(x_q, p_q[1], 1'b0);
          y_q         <= fx_add(y_q, p_q[3], 1'b0);
          z_q         <= fx_add(z_q, p_q[6], 1'b0);
          cnt_q       <= cnt_d;
          out_valid_q <= 1'b1;
          if ((nsteps_q != ZERO_C) && (cnt_d == nsteps_q)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (pause) begin
            state_q <= S_HOLD;
          end else begin
            phase_q <= 3'd0;
            state_q <= S_MUL;
          end
        end
        S_HOLD: begin
          if (!pause) begin
            phase_q <= 3'd0;
            state_q <= S_MUL;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign z          = z_q;
  assign out_valid  = out_valid_q;
  assign step_count = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lorenz_solver_seq.sv
// Bench for lorenz_solver_seq: table-driven runs against a fixed-point golden
// model via an output scoreboard, plus reset, pause, restart and saturation sequences.
module tb_lorenz_solver_seq;

  localparam int     W   = 27;
  localparam int     CW  = 16;
  localparam longint ONE = 64'sd1048576;
  localparam longint LIM = 64'sd67108864;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, start, pause;
  logic [CW-1:0]       num_steps;
  logic signed [W-1:0] dt, sigma, beta, rho, init_x, init_y, init_z;
  logic signed [W-1:0] x1, y1, z1, x2, y2, z2;
  logic                ov1, ov2, busy1, busy2, done1, done2;
  logic [CW-1:0]       cnt1, cnt2;

  lorenz_solver_seq #(.WIDTH(W), .FRAC(20), .CNT_W(CW), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .num_steps(num_steps),
    .dt(dt), .sigma(sigma), .beta(beta), .rho(rho),
    .init_x(init_x), .init_y(init_y), .init_z(init_z),
    .x(x1), .y(y1), .z(z1), .out_valid(ov1), .step_count(cnt1), .busy(busy1), .done(done1));

  lorenz_solver_seq #(.WIDTH(W), .FRAC(20), .CNT_W(CW), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .num_steps(num_steps),
    .dt(dt), .sigma(sigma), .beta(beta), .rho(rho),
    .init_x(init_x), .init_y(init_y), .init_z(init_z),
    .x(x2), .y(y2), .z(z2), .out_valid(ov2), .step_count(cnt2), .busy(busy2), .done(done2));

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint x; longint y; longint z; int cnt; } exp_t;
  exp_t sbq[$];

  typedef struct {
    longint sigma; longint rho; longint beta; longint dt;
    longint ix; longint iy; longint iz;
    int n; bit chk_x; longint exp_x;
  } vec_t;
  vec_t tbl[4];

  function automatic longint fit(input longint v, input bit sat);
    longint r;
    if (sat) begin
      if (v > LIM - 1) r = LIM - 1;
      else if (v < -LIM) r = -LIM;
      else r = v;
    end else begin
      r = v & (2 * LIM - 1);
      if (r >= LIM) r = r - 2 * LIM;
    end
    return r;
  endfunction

  function automatic longint fmul(input longint a, input longint b, input bit sat);
    longint p, s, r;
    p = a * b;
    s = p >>> 20;
    if (sat) return fit(s, 1'b1);
    r = s & (LIM - 1);
    if (p < 0) r = r - LIM;
    return r;
  endfunction

  task automatic m_step(inout longint x, inout longint y, inout longint z,
                        input vec_t v, input bit sat);
    longint p0, p1, p2, p3, p4, p5, p6;
    p0 = fmul(v.sigma, fit(y - x, sat), sat);
    p1 = fmul(p0, v.dt, sat);
    p2 = fmul(x, fit(v.rho - z, sat), sat);
    p3 = fmul(fit(p2 - y, sat), v.dt, sat);
    p4 = fmul(x, y, sat);
    p5 = fmul(v.beta, z, sat);
    p6 = fmul(fit(p4 - p5, sat), v.dt, sat);
    x = fit(x + p1, sat);
    y = fit(y + p3, sat);
    z = fit(z + p6, sat);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    ncmp++;
    if (d > tol) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d +/- %0d (cycle %0d)", nm, act, exp, tol, cyc);
    end
  endtask

  // every clock advance samples on the falling edge and retires scoreboard entries
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (ov1) begin
      if (sbq.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL sb_unexpected_out_valid: got a pulse at cycle %0d, want none", cyc);
      end else begin
        e = sbq.pop_front();
        chk_tol("sb_x", x1, e.x, 2);
        chk_tol("sb_y", y1, e.y, 2);
        chk_tol("sb_z", z1, e.z, 2);
        chk("sb_step_count", cnt1, e.cnt);
      end
    end
  endtask

  task automatic wait_ov(input int ref_c, input int lat, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!got) begin
        tick();
        if (ov1) got = 1'b1;
      end
    end
    chk({nm, "_seen"}, got, 1);
    if (got) chk(nm, cyc - ref_c, lat);
  endtask

  task automatic set_inputs(input vec_t v);
    sigma = v.sigma[W-1:0]; rho = v.rho[W-1:0]; beta = v.beta[W-1:0]; dt = v.dt[W-1:0];
    init_x = v.ix[W-1:0]; init_y = v.iy[W-1:0]; init_z = v.iz[W-1:0];
    num_steps = v.n[CW-1:0];
  endtask

  task automatic push_model(input vec_t v, input int n, input bit sat);
    longint mx, my, mz;
    exp_t e;
    mx = v.ix; my = v.iy; mz = v.iz;
    for (int k = 1; k <= n; k++) begin
      m_step(mx, my, mz, v, sat);
      e.x = mx; e.y = my; e.z = mz; e.cnt = k;
      sbq.push_back(e);
    end
  endtask

  task automatic do_start(output int t0);
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    tick();
    chk("busy_after_start", busy1, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_x"}, x1, 0); chk({nm, "_y"}, y1, 0); chk({nm, "_z"}, z1, 0);
    chk({nm, "_step_count"}, cnt1, 0); chk({nm, "_out_valid"}, ov1, 0);
    chk({nm, "_busy"}, busy1, 0); chk({nm, "_done"}, done1, 0);
  endtask

  task automatic run_case(input vec_t v);
    int t0, rc, changes;
    longint sx, sy, sz;
    set_inputs(v);
    push_model(v, v.n, 1'b1);
    do_start(t0);
    rc = t0;
    for (int k = 0; k < v.n; k++) begin
      wait_ov(rc, (k == 0) ? 9 : 8, "step_latency");
      rc = cyc;
      if (k == 0 && v.chk_x) chk("first_x_exact", x1, v.exp_x);
    end
    tick();
    chk("run_done", done1, 1);
    chk("run_busy", busy1, 0);
    chk("run_step_count", cnt1, v.n);
    sx = x1; sy = y1; sz = z1;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (x1 != sx || y1 != sy || z1 != sz || ov1 || !done1) changes++;
    end
    chk("frozen_after_done", changes, 0);
  endtask

  initial begin
    int t0, rc, changes;
    longint sx, wx, wy, wz;
    vec_t v;

    tbl[0] = '{10 * ONE, 28 * ONE, 64'sh2AAAAA, 64'sh1000, -ONE, 64'sh1999A, 25 * ONE, 1, 1'b1, -64'sd1003520};
    tbl[1] = '{10 * ONE, 28 * ONE, 64'sh2AAAAA, 64'sh1000, -ONE, 64'sh1999A, 25 * ONE, 5, 1'b0, 64'sd0};
    tbl[2] = '{10 * ONE, 28 * ONE, 64'sh2AAAAA, 64'sh4000, ONE, ONE, ONE, 3, 1'b0, 64'sd0};
    tbl[3] = '{10 * ONE, 28 * ONE, 64'sh2AAAAA, 64'sh2000, 5 * ONE, -3 * ONE, 10 * ONE, 2, 1'b0, 64'sd0};

    reset = 1'b1; start = 1'b0; pause = 1'b0;
    set_inputs(tbl[0]);
    tick(); tick();
    chk_zero("reset_init");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_case(tbl[i]);

    // reset in the middle of a free run; a simultaneous start must lose
    v = tbl[0]; v.n = 0;
    set_inputs(v);
    push_model(v, 2, 1'b1);
    do_start(t0);
    wait_ov(t0, 9, "fr_step1");
    rc = cyc;
    wait_ov(rc, 8, "fr_step2");
    tick(); tick(); tick();
    reset = 1'b1; start = 1'b1;
    tick();
    chk_zero("reset_midrun");
    reset = 1'b0; start = 1'b0;
    tick();
    chk("start_lost_to_reset", busy1, 0);
    chk("sb_empty_after_reset", sbq.size(), 0);

    // pause during step 2 and release
    v = tbl[0]; v.n = 4;
    set_inputs(v);
    push_model(v, 4, 1'b1);
    do_start(t0);
    wait_ov(t0, 9, "pause_step1");
    rc = cyc;
    tick(); tick(); tick();
    pause = 1'b1;
    wait_ov(rc, 8, "pause_step2");
    sx = x1;
    changes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov1 || x1 != sx || !busy1) changes++;
    end
    chk("hold_frozen", changes, 0);
    chk("hold_step_count", cnt1, 2);
    pause = 1'b0;
    rc = cyc;
    // one edge to leave HOLD, then seven products and the update
    wait_ov(rc, 9, "resume_step3");
    rc = cyc;
    wait_ov(rc, 8, "pause_step4");
    tick();
    chk("pause_run_done", done1, 1);

    // start pulsed mid-run with new inputs must not reload
    v = tbl[0]; v.n = 4;
    set_inputs(v);
    push_model(v, 4, 1'b1);
    do_start(t0);
    wait_ov(t0, 9, "rs_step1");
    rc = cyc;
    tick();
    init_x = 7 * ONE; init_y = -2 * ONE; sigma = 3 * ONE; num_steps = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ov(rc, 8, "rs_step2");
    rc = cyc;
    wait_ov(rc, 8, "rs_step3");
    rc = cyc;
    wait_ov(rc, 8, "rs_step4");
    tick();
    chk("rs_step_count", cnt1, 4);
    chk("rs_done", done1, 1);

    // saturation versus wrap on a large x*y product
    v = '{10 * ONE, 28 * ONE, 64'sh2AAAAA, ONE, 60 * ONE, 60 * ONE, 64'sd0, 1, 1'b0, 64'sd0};
    set_inputs(v);
    push_model(v, 1, 1'b1);
    wx = v.ix; wy = v.iy; wz = v.iz;
    m_step(wx, wy, wz, v, 1'b0);
    do_start(t0);
    wait_ov(t0, 9, "sat_step1");
    chk("sat_z_clamped", z1, 64'sh3FFFFFF);
    chk("wrap_out_valid", ov2, 1);
    chk("wrap_x", x2, wx);
    chk("wrap_y", y2, wy);
    chk("wrap_z", z2, wz);
    chk("wrap_step_count", cnt2, 1);
    tick();
    chk("wrap_done", done2, 1);
    chk("wrap_busy", busy2, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
